// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port valid/ready memory:
// one transaction outstanding, one release cycle after each, watchdog-bounded.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_mem_valid,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic        grant,
    output logic        timeout_err
);
    typedef enum logic [1:0] { IDLE, BUSY, RELEASE } state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_last_grant;
    logic        r_grant;
    logic        r_timeout_err;
    logic        r_s_valid;
    logic [31:0] r_s_addr;
    logic [31:0] r_s_wdata;
    logic [3:0]  r_s_wstrb;
    logic        r_m0_ready;
    logic        r_m1_ready;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic [7:0]  r_wdog;

    logic        w_any;
    logic        w_winner;
    logic        w_done;
    logic        w_timeout;
    logic [31:0] w_ret_data;

    always_comb begin
        w_any      = m0_valid | m1_valid;
        // contention goes to the master that did not own the previous transaction
        w_winner   = (m0_valid && m1_valid) ? ~r_last_grant : m1_valid;
        w_done     = (r_state == BUSY) && s_mem_ready;
        w_timeout  = (r_state == BUSY) && !s_mem_ready && (r_wdog == WDOG_LAST);
        w_ret_data = w_done ? s_mem_rdata : TIMEOUT_RDATA;
        w_next     = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = BUSY;
            BUSY:    if (w_done || w_timeout) w_next = RELEASE;
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant  <= 1'b1;
            r_grant       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_s_valid     <= 1'b0;
            r_s_addr      <= '0;
            r_s_wdata     <= '0;
            r_s_wstrb     <= '0;
            r_m0_ready    <= 1'b0;
            r_m1_ready    <= 1'b0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
            r_wdog        <= '0;
        end else begin
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_s_addr     <= w_winner ? m1_addr  : m0_addr;
                        r_s_wdata    <= w_winner ? m1_wdata : m0_wdata;
                        r_s_wstrb    <= w_winner ? m1_wstrb : m0_wstrb;
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_wdog       <= '0;
                        r_s_valid    <= 1'b1;
                    end
                end
                BUSY: begin
                    r_wdog <= r_wdog + 8'd1;
                    if (w_done || w_timeout) begin
                        r_s_valid <= 1'b0;
                        if (r_grant) begin
                            r_m1_ready <= 1'b1;
                            r_m1_rdata <= w_ret_data;
                        end else begin
                            r_m0_ready <= 1'b1;
                            r_m0_rdata <= w_ret_data;
                        end
                        if (w_timeout) r_timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_mem_valid = r_s_valid;
    assign s_mem_addr  = r_s_addr;
    assign s_mem_wdata = r_s_wdata;
    assign s_mem_wstrb = r_s_wstrb;
    assign m0_ready    = r_m0_ready;
    assign m1_ready    = r_m1_ready;
    assign m0_rdata    = r_m0_rdata;
    assign m1_rdata    = r_m1_rdata;
    assign grant       = r_grant;
    assign timeout_err = r_timeout_err;

endmodule
